lsu_writeback: RTL and testbench
================================

Name: lsu_writeback

Overview:
- Multi-cycle load/store unit between the execute stage and the register-file write port.
- Accepts one memory op per handshake and drives a valid/ready word-wide memory bus.
- For loads: extracts and sign/zero-extends the addressed byte/half/word, then issues a single-cycle register write (wen/waddr/wdata) to the register file.
- Signals completion to the core controller with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 5, register index width (rd / rf_waddr)
- DATA_WIDTH, 32, register and memory data width; only 32 is supported

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  execute stage presents a load/store
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (size and signedness)
- req_addr  input  32  effective byte address
- req_wdata  input  DATA_WIDTH  store data (rs2)
- req_rd  input  ADDR_WIDTH  load destination register
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_req_wen  output  1  1 = write
- mem_req_wmask  output  4  byte-lane write strobes
- mem_req_wdata  output  32  lane-shifted store data
- mem_rsp_valid  input  1  response (read data or write ack) valid
- mem_rsp_rdata  input  32  read word
- rf_wen  output  1  register-file write enable
- rf_waddr  output  ADDR_WIDTH  register-file write address
- rf_wdata  output  DATA_WIDTH  extended load data
- done  output  1  one-cycle completion pulse
- err  output  1  with done: misaligned or illegal funct3, no memory access performed

Behaviour:
- State machine: IDLE, REQ, WAIT, WB, ERR. Reset state is IDLE.
- Reset values: all outputs 0 except req_ready=1 (IDLE). Captured request registers are cleared to 0.
- Reset mid-operation returns to IDLE the next edge, abandoning any outstanding bus transaction.
- IDLE: req_ready=1. On req_valid, capture is_store, funct3, addr, wdata and rd.
  - Legal and aligned request: go to REQ.
  - Otherwise: go to ERR.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- REQ: mem_req_valid=1. Address, wen, wmask and wdata are driven from the captured registers and held stable until mem_req_ready. On the ready cycle, go to WAIT. A mem_rsp_valid seen in REQ is ignored.
- Store lanes, with off=addr[1:0]:
  - wmask: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111.
  - wdata: req_wdata<<(8*off).
  - Loads drive wmask=0, wen=0.
- WAIT: hold until mem_rsp_valid. On the response:
  - Loads: register the extracted data, go to WB.
  - Stores: go to WB with no data.
- Load extraction: s = mem_rsp_rdata>>(8*off).
  - LB: sign-extend s[7:0].
  - LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0].
  - LHU: zero-extend s[15:0].
  - LW: s.
- WB: exactly one cycle, then IDLE.
  - done=1.
  - rf_wen=1 only for a load with rd!=0.
  - rf_waddr=rd and rf_wdata=extracted data; both are 0 when rf_wen=0.
- ERR: exactly one cycle, then IDLE. done=1, err=1, rf_wen=0, mem_req_valid never asserted.
- Latency: a load accepted at cycle 0, with mem_req_ready=1 at cycle 1 and mem_rsp_valid at cycle 2, writes the register file in cycle 3.
- Back-to-back: the next request can be accepted the cycle after WB/ERR, i.e. no overlap; req_ready=0 during WB/ERR.
- mem_rsp_valid in IDLE, WB or ERR is ignored and causes no state change.

Test Plan:
- LW addr 0x80000010, rd=5, rdata 0xDEADBEEF, ready and rsp each after 0 wait cycles -> rf_wen=1, waddr=5, wdata=0xDEADBEEF in cycle 3 with done=1.
- LB addr 0x80000003, rdata 0x80FF1234 -> wdata 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x...2, rdata 0x80FF1234 -> 0x000080FF.
- SH addr 0x80000002, rs2 0x0000ABCD, mem_req_ready held low 3 cycles -> request held stable with mem_req_addr 0x80000000, wmask 4'b1100, wdata 0xABCD0000 until ready. Then done with rf_wen=0 after rsp.
- LW addr 0x80000001 and funct3 011 load -> ERR: done=1, err=1 one cycle after accept, mem_req_valid never 1.
- LW rd=0 -> done=1, rf_wen=0. A spurious mem_rsp_valid in IDLE or REQ -> no state change.
- rst asserted while in WAIT -> next cycle IDLE, req_ready=1, all other outputs 0. A late mem_rsp_valid after that produces no rf_wen and no done.

Source files
------------

// File: rtl/lsu_writeback.sv
// Load/store unit: one word-wide bus transaction per request,
// load data extended and written back to the register file.
module lsu_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [ADDR_WIDTH-1:0] req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  output logic                  mem_req_wen,
  output logic [3:0]            mem_req_wmask,
  output logic [31:0]           mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, WB, ERR
  } state_t;

  state_t                state;
  logic                  cap_store;
  logic [2:0]            cap_f3;
  logic [31:0]           cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [ADDR_WIDTH-1:0] cap_rd;

  logic [1:0]            off;
  logic                  req_ok;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;

  function automatic logic legal(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    unique case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~st;
      3'b101:  ok = ~st & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign off    = cap_addr[1:0];
  assign req_ok = legal(req_is_store, req_funct3, req_addr[1:0]);

  always_comb begin
    lane_mask = 4'b0000;
    if (cap_store) begin
      unique case (cap_f3[1:0])
        2'b00:   lane_mask = 4'b0001 << off;
        2'b01:   lane_mask = 4'b0011 << off;
        2'b10:   lane_mask = 4'b1111;
        default: lane_mask = 4'b0000;
      endcase
    end
  end

  // Bus fields come straight from the captured request, so they
  // stay stable for the whole REQ phase.
  assign mem_req_addr  = mem_req_valid ? {cap_addr[31:2], 2'b00} : '0;
  assign mem_req_wen   = mem_req_valid & cap_store;
  assign mem_req_wmask = mem_req_valid ? lane_mask : '0;
  assign mem_req_wdata = mem_req_valid ? cap_wdata << {off, 3'b000} : '0;

  always_comb begin
    shifted = mem_rsp_rdata >> {off, 3'b000};
    ext     = shifted;
    unique case (cap_f3[1:0])
      2'b00:   ext = {{24{shifted[7] & ~cap_f3[2]}}, shifted[7:0]};
      2'b01:   ext = {{16{shifted[15] & ~cap_f3[2]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      rf_wen        <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      cap_store     <= 1'b0;
      cap_f3        <= '0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_rd        <= '0;
    end else begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cap_store <= req_is_store;
            cap_f3    <= req_funct3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_rd    <= req_rd;
            req_ready <= 1'b0;
            if (req_ok) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end else begin
              state <= ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= WB;
            done  <= 1'b1;
            if (!cap_store && cap_rd != '0) begin
              rf_wen   <= 1'b1;
              rf_waddr <= cap_rd;
              rf_wdata <= ext;
            end
          end
        end
        WB, ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_writeback.sv
// Randomized scoreboard bench for lsu_writeback against a
// byte-level reference model.
module tb_lsu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;
  logic        err;

  lsu_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: compares every completion and every bus request.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("err", 32'(err), 32'(e.err));
          check("rf_wen", 32'(rf_wen), 32'(e.wen));
          check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
          check("rf_wdata", rf_wdata, e.wdata);
          check("latency", 32'(cyc), 32'(e.due));
          check("ready_in_done", 32'(req_ready), 32'(0));
          check("bus_in_done", 32'(mem_req_valid), 32'(0));
        end
      end else begin
        if (rf_wen) check("wen_without_done", 32'(rf_wen), 32'(0));
        if (err) check("err_without_done", 32'(err), 32'(0));
      end
      if (mem_req_valid) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus_req", 32'(mem_req_valid), 32'(0));
        end else begin
          check("bus_addr", mem_req_addr, bus_q[0].addr);
          check("bus_wen", 32'(mem_req_wen), 32'(bus_q[0].wen));
          check("bus_wmask", 32'(mem_req_wmask), 32'(bus_q[0].wmask));
          if (bus_q[0].wen) check("bus_wdata", mem_req_wdata, bus_q[0].wdata);
        end
      end
    end
  end

  task automatic run_op(input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input int d, input int r, input bit spur,
                        input bit rst_wait);
    int         n;
    int         off;
    bit         legal;
    bit         ok;
    logic [63:0] m;
    logic [63:0] v;
    exp_t       e;
    bus_t       b;

    n     = 1 << f3[1:0];
    off   = addr % 4;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
               : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ok    = legal && (addr % n == 0);
    m     = (64'd1 << (8 * n)) - 64'd1;
    v     = ({32'd0, rdata} >> (8 * off)) & m;
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~m;

    e.err   = !ok;
    e.wen   = ok && !st && rd != 0;
    e.waddr = e.wen ? rd : 5'd0;
    e.wdata = e.wen ? v[31:0] : 32'd0;
    b.addr  = {addr[31:2], 2'b00};
    b.wen   = st;
    b.wmask = st ? 4'(((1 << n) - 1) << off) : 4'd0;
    b.wdata = wd << (8 * off);

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'(1));
      return;
    end
    if (spur) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = $urandom;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("idle_after_spur", 32'(req_ready), 32'(1));
    end

    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    req_rd       = rd;
    e.due        = cyc + (ok ? d + r + 3 : 1);
    exp_q.push_back(e);
    if (ok) bus_q.push_back(b);
    @(negedge clk);
    req_valid = 1'b0;

    if (ok) begin
      for (int i = 0; i <= d; i++) begin
        mem_req_ready = (i == d);
        mem_rsp_valid = spur && i == 0;
        mem_rsp_rdata = $urandom;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      void'(bus_q.pop_front());
      if (rst_wait) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_mem_valid", 32'(mem_req_valid), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_rf_wen", 32'(rf_wen), 32'(0));
        check("rst_rf_wdata", rf_wdata, 32'(0));
        check("rst_err", 32'(err), 32'(0));
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rsp_ready", 32'(req_ready), 32'(1));
        return;
      end
      repeat (r) @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_is_store  = 1'b0;
    req_funct3    = 3'd0;
    req_addr      = 32'd0;
    req_wdata     = 32'd0;
    req_rd        = 5'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'(1));
    check("reset_mem_valid", 32'(mem_req_valid), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_rf_wen", 32'(rf_wen), 32'(0));
    check("reset_mem_addr", mem_req_addr, 32'(0));
    rst = 1'b0;

    run_op(0, 3'b010, 32'h8000_0010, 0, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    run_op(0, 3'b000, 32'h8000_0003, 0, 6, 32'h80FF_1234, 0, 0, 0, 0);
    run_op(0, 3'b100, 32'h8000_0003, 0, 7, 32'h80FF_1234, 1, 0, 0, 0);
    run_op(0, 3'b101, 32'h8000_0002, 0, 8, 32'h80FF_1234, 0, 2, 0, 0);
    run_op(1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 3, 1, 0, 0);
    run_op(0, 3'b010, 32'h8000_0001, 0, 9, 0, 0, 0, 0, 0);
    run_op(0, 3'b011, 32'h8000_0000, 0, 9, 0, 0, 0, 0, 0);
    run_op(0, 3'b010, 32'h8000_0004, 0, 0, 32'h1234_5678, 0, 0, 1, 0);
    run_op(0, 3'b001, 32'h8000_0006, 0, 3, 32'h9876_5432, 2, 1, 1, 0);
    run_op(0, 3'b010, 32'h8000_0008, 0, 4, 32'hCAFE_F00D, 1, 0, 0, 1);
    run_op(0, 3'b010, 32'h8000_000C, 0, 4, 32'h0BAD_CAFE, 0, 0, 0, 0);

    for (int k = 0; k < 250; k++) begin
      run_op($urandom_range(0, 1) == 1, 3'($urandom),
             32'h8000_0000 | 32'($urandom_range(0, 255)),
             $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0);
    end

    repeat (10) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'(0));
    check("bus_queue_drained", 32'(bus_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
